// File: rtl/msdap_input_loader.sv
// msdap_input_loader: deserializes L/R serial streams into Rj, coefficient and circular data memories,
// tracking the data write pointer and the all-zero sleep condition.
module msdap_input_loader #(
  parameter int RJ_WORDS    = 16,
  parameter int COEFF_WORDS = 512,
  parameter int ZERO_LIMIT  = 800
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bit_en_i,
  input  logic        frame_i,
  input  logic        in_l_i,
  input  logic        in_r_i,
  input  logic        soft_clear_i,
  output logic        rj_wr_en_o,
  output logic [3:0]  rj_addr_o,
  output logic        coeff_wr_en_o,
  output logic [8:0]  coeff_addr_o,
  output logic        data_wr_en_o,
  output logic [7:0]  data_addr_o,
  output logic [15:0] word_l_o,
  output logic [15:0] word_r_o,
  output logic        mem_clear_o,
  output logic        sample_valid_o,
  output logic        sleep_o,
  output logic [1:0]  state_o
);
  typedef enum logic [1:0] {LOAD_RJ = 2'd0, LOAD_COEFF = 2'd1, RUN = 2'd2} state_t;
  localparam int ZW = $clog2(ZERO_LIMIT + 1);
  state_t        state_q;
  logic [15:0]   sh_l_q, sh_r_q;
  logic [3:0]    bit_cnt_q;
  logic [8:0]    word_cnt_q;
  logic [ZW-1:0] zero_cnt_q, zero_cnt_d;
  logic [15:0]   full_l, full_r;
  logic          done, at_limit;
  assign full_l  = {sh_l_q[14:0], in_l_i};
  assign full_r  = {sh_r_q[14:0], in_r_i};
  // bit_cnt_q==0 means no word in progress; the 16th bit wraps it back to 0
  assign done    = bit_en_i && !frame_i && bit_cnt_q == 4'd15 && !soft_clear_i;
  assign state_o = state_q;
  always_comb begin
    zero_cnt_d = (|full_l || |full_r) ? '0 :
                 (zero_cnt_q == ZW'(ZERO_LIMIT)) ? zero_cnt_q : zero_cnt_q + 1'b1;
    at_limit   = zero_cnt_d == ZW'(ZERO_LIMIT);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= LOAD_RJ;
      sh_l_q         <= '0;
      sh_r_q         <= '0;
      bit_cnt_q      <= '0;
      word_cnt_q     <= '0;
      zero_cnt_q     <= '0;
      rj_wr_en_o     <= 1'b0;
      rj_addr_o      <= '0;
      coeff_wr_en_o  <= 1'b0;
      coeff_addr_o   <= '0;
      data_wr_en_o   <= 1'b0;
      data_addr_o    <= '0;
      word_l_o       <= '0;
      word_r_o       <= '0;
      mem_clear_o    <= 1'b0;
      sample_valid_o <= 1'b0;
      sleep_o        <= 1'b0;
    end else begin
      rj_wr_en_o     <= 1'b0;
      coeff_wr_en_o  <= 1'b0;
      data_wr_en_o   <= 1'b0;
      sample_valid_o <= 1'b0;
      mem_clear_o    <= soft_clear_i;
      if (data_wr_en_o) data_addr_o <= data_addr_o + 8'd1;
      if (soft_clear_i) begin
        sh_l_q      <= '0;
        sh_r_q      <= '0;
        bit_cnt_q   <= '0;
        data_addr_o <= '0;
        zero_cnt_q  <= '0;
        sleep_o     <= 1'b0;
      end else if (bit_en_i && frame_i) begin
        sh_l_q    <= {15'b0, in_l_i};
        sh_r_q    <= {15'b0, in_r_i};
        bit_cnt_q <= 4'd1;
      end else if (bit_en_i && bit_cnt_q != 4'd0) begin
        sh_l_q    <= full_l;
        sh_r_q    <= full_r;
        bit_cnt_q <= bit_cnt_q + 4'd1;
      end
      if (done) begin
        word_l_o <= full_l;
        word_r_o <= full_r;
        if (state_q == LOAD_RJ) begin
          rj_wr_en_o <= 1'b1;
          rj_addr_o  <= word_cnt_q[3:0];
          word_cnt_q <= (word_cnt_q == 9'(RJ_WORDS - 1)) ? '0 : word_cnt_q + 9'd1;
          if (word_cnt_q == 9'(RJ_WORDS - 1)) state_q <= LOAD_COEFF;
        end else if (state_q == LOAD_COEFF) begin
          coeff_wr_en_o <= 1'b1;
          coeff_addr_o  <= word_cnt_q;
          word_cnt_q    <= (word_cnt_q == 9'(COEFF_WORDS - 1)) ? '0 : word_cnt_q + 9'd1;
          if (word_cnt_q == 9'(COEFF_WORDS - 1)) begin
            state_q     <= RUN;
            data_addr_o <= '0;
          end
        end else begin
          data_wr_en_o   <= 1'b1;
          zero_cnt_q     <= zero_cnt_d;
          sleep_o        <= at_limit;
          sample_valid_o <= !at_limit;
        end
      end
    end
  end
endmodule

// File: tb/tb_msdap_input_loader.sv
// tb_msdap_input_loader: directed stimulus pushes expected writes into a queue; a negedge monitor
// pops and compares every write the DUT presents, including its latency.
module tb_msdap_input_loader;
  logic clk = 0, rst_n = 0, bit_en = 0, frame = 0, in_l = 0, in_r = 0, soft_clear = 0;
  logic rj_wr_en, coeff_wr_en, data_wr_en, mem_clear, sample_valid, sleep;
  logic [3:0] rj_addr;
  logic [8:0] coeff_addr;
  logic [7:0] data_addr;
  logic [15:0] word_l, word_r;
  logic [1:0] state;

  msdap_input_loader dut (
    .clk(clk), .rst_n(rst_n), .bit_en_i(bit_en), .frame_i(frame), .in_l_i(in_l), .in_r_i(in_r),
    .soft_clear_i(soft_clear), .rj_wr_en_o(rj_wr_en), .rj_addr_o(rj_addr),
    .coeff_wr_en_o(coeff_wr_en), .coeff_addr_o(coeff_addr), .data_wr_en_o(data_wr_en),
    .data_addr_o(data_addr), .word_l_o(word_l), .word_r_o(word_r), .mem_clear_o(mem_clear),
    .sample_valid_o(sample_valid), .sleep_o(sleep), .state_o(state)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]  en;
    int          addr;
    logic [15:0] wl, wr;
    logic        sv, sl;
    int          st, at;
  } exp_t;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0, n_mc = 0;
  int m_rj = 0, m_co = 0, m_da = 0, m_zc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic f, input logic l, input logic r);
    bit_en = 1; frame = f; in_l = l; in_r = r;
    tick;
    bit_en = 0; frame = 0;
    tick;
  endtask

  task automatic send_word(input logic [15:0] l, input logic [15:0] r);
    exp_t e;
    e.wl = l; e.wr = r; e.sv = 0; e.sl = 0;
    if (m_rj < 16) begin
      e.en = 3'b100; e.addr = m_rj; m_rj++; e.st = (m_rj == 16) ? 1 : 0;
    end else if (m_co < 512) begin
      e.en = 3'b010; e.addr = m_co; m_co++; e.st = (m_co == 512) ? 2 : 1;
    end else begin
      e.en = 3'b001; e.addr = m_da; m_da = (m_da + 1) % 256;
      m_zc = (l == 0 && r == 0) ? ((m_zc < 800) ? m_zc + 1 : 800) : 0;
      e.sl = (m_zc == 800); e.sv = !e.sl; e.st = 2;
    end
    for (int i = 15; i >= 0; i--) begin
      if (i == 0) begin
        e.at = cyc + 1;
        q.push_back(e);
      end
      send_bit(i == 15, l[i], r[i]);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (mem_clear) n_mc++;
      if (rj_wr_en || coeff_wr_en || data_wr_en || sample_valid) begin
        if (q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_write: got en=%b%b%b sv=%b expected no write (cycle %0d)",
                   rj_wr_en, coeff_wr_en, data_wr_en, sample_valid, cyc);
        end else begin
          e = q.pop_front();
          chk("write_enables", {rj_wr_en, coeff_wr_en, data_wr_en}, e.en);
          chk("write_addr", e.en[2] ? rj_addr : e.en[1] ? coeff_addr : data_addr, e.addr);
          chk("word_l", word_l, e.wl);
          chk("word_r", word_r, e.wr);
          chk("sample_valid", sample_valid, e.sv);
          chk("sleep", sleep, e.sl);
          chk("state", state, e.st);
          chk("latency", cyc, e.at);
        end
      end
    end
  end

  initial begin
    repeat (3) tick;
    rst_n = 1;
    tick;
    chk("rst_state", state, 0);
    chk("rst_addrs", {rj_addr, coeff_addr, data_addr}, 0);
    chk("rst_strobes", {rj_wr_en, coeff_wr_en, data_wr_en, sample_valid, sleep, mem_clear}, 0);
    chk("rst_words", {word_l, word_r}, 0);
    for (int i = 0; i < 5; i++) send_bit(0, 1, 1);
    for (int i = 1; i <= 16; i++) send_word(16'(i), 16'(i));
    repeat (2) tick;
    chk("state_after_rj", state, 1);
    for (int i = 0; i < 512; i++) send_word(16'(i), 16'(511 - i));
    repeat (2) tick;
    chk("state_after_coeff", state, 2);
    chk("coeff_last_addr", coeff_addr, 511);
    chk("coeff_last_word", word_l, 16'h01FF);
    chk("run_start_addr", data_addr, 0);
    for (int i = 0; i < 258; i++) send_word(16'h1234, 16'hABCD);
    for (int i = 0; i < 800; i++) send_word(16'h0000, 16'h0000);
    repeat (2) tick;
    chk("sleep_held", sleep, 1);
    send_word(16'h0005, 16'h0000);
    repeat (2) tick;
    chk("sleep_cleared", sleep, 0);
    send_bit(1, 1, 1);
    for (int i = 0; i < 6; i++) send_bit(0, 1, 1);
    send_word(16'h4321, 16'h8765);
    send_word(16'h1111, 16'h2222);
    repeat (2) tick;
    chk("addr_before_clear", data_addr, 37);
    for (int i = 0; i < 5; i++) send_bit(i == 0, 1, 0);
    soft_clear = 1;
    tick;
    soft_clear = 0;
    m_da = 0; m_zc = 0;
    tick;
    chk("addr_after_clear", data_addr, 0);
    chk("state_after_clear", state, 2);
    for (int i = 0; i < 3; i++) send_bit(0, 1, 1);
    send_word(16'h00AA, 16'h0055);
    repeat (2) tick;
    for (int i = 0; i < 4; i++) send_bit(i == 0, 1, 1);
    rst_n = 0;
    tick;
    chk("async_reset_state", state, 0);
    chk("async_reset_addr", data_addr, 0);
    rst_n = 1;
    m_rj = 0; m_co = 0; m_da = 0; m_zc = 0;
    send_word(16'hBEEF, 16'hCAFE);
    for (int i = 0; i < 10 && q.size() != 0; i++) tick;
    chk("queue_drained", q.size(), 0);
    chk("mem_clear_pulses", n_mc, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
